seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed seven-segment scan controller for the calculator's result display. It advances one digit per `rotate` strobe from the rotate tick generator. Each step drives one active-low anode and the matching cathode pattern. A one-entry pending buffer with a valid/ready handshake lets the stack/queue datapath post new values, and new values take effect only at frame boundaries so the display never tears.

## Interface
- `DIGITS`, default 4: number of multiplexed digits; legal range 2–8.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `rotate` in 1: one-cycle advance strobe from the rotate tick generator.
- `load_valid` in 1: producer has a value on `load_data`/`load_neg`.
- `load_ready` out 1: pending buffer empty; a value is accepted when `load_valid && load_ready` at a rising edge.
- `load_data` in 4*DIGITS: hex nibbles; nibble i (bits 4i+3:4i) drives digit i, and digit 0 is the rightmost.
- `load_neg` in 1: the value is negative; captured together with `load_data`.
- `lz_blank` in 1: leading-zero blanking enable; static configuration, sampled on each `rotate`.
- `an` out DIGITS: anode select, active-low one-hot, or all ones when blank.
- `seg` out 7: cathodes, active-low, ordered {g,f,e,d,c,b,a}.
- `frame_done` out 1: one-cycle pulse when the scan wraps to digit 0.

## Operation
- Registers:
  - `idx` (digit index, 0..DIGITS-1).
  - `disp_val`/`disp_neg`: the shown value.
  - `pend_val`/`pend_neg`/`pend_full`: the pending buffer.
  - `started`: set on the first `rotate` after reset.
  - Registered `an`, `seg`, `frame_done`.
- States: BLANK (after reset, `started`=0) and SCAN. The first `rotate` in BLANK moves to SCAN and renders digit 0 with `idx`=0. Each later `rotate` sets `idx` to `idx+1`, wrapping from DIGITS-1 to 0, and renders the new `idx`.
- `load_ready` = !`pend_full`, driven from registers only. On accept: `pend_val`←`load_data`, `pend_neg`←`load_neg`, `pend_full`←1.
- Frame apply: on a `rotate` that wraps `idx` to 0 (or the first `rotate` out of BLANK) with `pend_full`=1:
  - `disp_*`←`pend_*` and `pend_full`←0.
  - The digit rendered by that same `rotate` already uses the new value.
  - Accept and apply can never coincide, because `load_ready` is low while full.
- Render of digit i, in priority order:
  1. i = DIGITS-1 and `disp_neg`=1 → minus, 0111111.
  2. `lz_blank`=1, i≠0, and every nibble at positions ≥ i is zero → blank, 1111111, but `an` is still driven for that digit.
  3. Otherwise standard hex decode of nibble i.
- Hex decode examples: 0→1000000, 1→1111001, 2→0100100, 7→1111000, 8→0000000, A→0001000, F→0001110.
- `an` = ~(1<<i) while in SCAN.
- Without `rotate`, all outputs hold.
- `rotate` stuck high advances one digit per cycle. This is legal and needs no special handling.

## Timing
- Reset values, in the cycle after `rst` is sampled high:
  - `an` = all ones, `seg` = 1111111, `frame_done` = 0.
  - `load_ready` = 0 while `rst` is high, and 1 from the first cycle after it drops.
  - `idx` = 0, `disp_val` = 0, `disp_neg` = 0, `pend_full` = 0, state BLANK.
- `rst` mid-frame or with `pend_full`=1 discards the pending value and blanks the display at the next edge.
- `rotate` at edge N → new `an`/`seg` visible after edge N, a latency of 1 cycle.
- `frame_done` = 1 for exactly the cycle after any `rotate` that wraps `idx` to 0, including the first `rotate` out of BLANK. It is coincident with digit 0 being driven.
- A value accepted at edge N is shown starting at the next wrap strobe after N.
- A load accepted on the same edge as a wrap strobe misses that wrap and waits one full frame.
- `load_ready` falls the cycle after an accept and rises the cycle after the applying `rotate`.

## Test plan
- **Reset, then no rotate for 50 cycles:** `an`=1111, `seg`=1111111, `load_ready`=1, `frame_done`=0 throughout.
- **Load 0x1A70 (neg=0, `lz_blank`=0), then 8 rotates spaced 5 cycles apart:**
  - First frame: `an` sequence 1110,1101,1011,0111 with `seg` 1000000,1111000,0001000,1111001.
  - `frame_done` pulses after rotates 1 and 5.
  - `load_ready` low from accept until after rotate 1.
- **Load 0x0007, `lz_blank`=1:** digit 0 shows 1111000; digits 1–3 show 1111111 with their anodes still cycling. Repeat with `lz_blank`=0: digits 1–3 show 1000000.
- **Load 0x0012 with neg=1, `lz_blank`=1:** digit 3 shows 0111111, digit 2 blank, digit 1 1111001, digit 0 0100100.
- **Mid-frame back-to-back loads:**
  - Load A mid-frame is accepted; load B is held off (`load_ready`=0) until the wrap.
  - A appears at the wrap; B is accepted the next cycle and appears one frame later.
  - Loading on the wrap-strobe edge itself delays that value by one full frame.
- **Assert `rst` one cycle mid-frame with `pend_full`=1:** next cycle `an`=1111, `load_ready`=0; after release, the first rotate shows 1000000 on digit 0 and the pending value is lost.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: one digit per rotate strobe, active-low anodes/cathodes,
// with a one-entry pending buffer whose value is swapped in only at frame boundaries.
module seg_scan_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rotate,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic                  load_neg,
  input  logic                  lz_blank,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  frame_done
);

  localparam int             IW   = $clog2(DIGITS);
  localparam logic [IW-1:0]  LAST = IW'(DIGITS - 1);

  typedef enum logic {BLANK, SCAN} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   disp_val_q, disp_val_d;
  logic                  disp_neg_q, disp_neg_d;
  logic [4*DIGITS-1:0]   pend_val_q, pend_val_d;
  logic                  pend_neg_q, pend_neg_d;
  logic                  pend_full_q, pend_full_d;
  logic                  ready_q, ready_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  frame_done_q, frame_done_d;

  logic                  wrap;
  logic [3:0]            nib;
  logic                  nz_hi;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    disp_val_d   = disp_val_q;
    disp_neg_d   = disp_neg_q;
    pend_val_d   = pend_val_q;
    pend_neg_d   = pend_neg_q;
    pend_full_d  = pend_full_q;
    an_d         = an_q;
    seg_d        = seg_q;
    frame_done_d = 1'b0;
    wrap         = 1'b0;
    nib          = 4'h0;
    nz_hi        = 1'b0;

    if (load_valid && ready_q) begin
      pend_val_d  = load_data;
      pend_neg_d  = load_neg;
      pend_full_d = 1'b1;
    end

    if (rotate) begin
      if (state_q == BLANK || idx_q == LAST) begin
        state_d = SCAN;
        idx_d   = '0;
        wrap    = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
      // Swap in the pending value before rendering so digit 0 of the frame already shows it.
      if (wrap && pend_full_q) begin
        disp_val_d  = pend_val_q;
        disp_neg_d  = pend_neg_q;
        pend_full_d = 1'b0;
      end
      frame_done_d = wrap;
    end

    for (int j = 0; j < DIGITS; j++) begin
      if (IW'(j) == idx_d) nib = disp_val_d[4*j +: 4];
      if (j >= int'(idx_d) && disp_val_d[4*j +: 4] != 4'h0) nz_hi = 1'b1;
    end

    if (rotate) begin
      for (int j = 0; j < DIGITS; j++) an_d[j] = (IW'(j) != idx_d);
      if (idx_d == LAST && disp_neg_d)                  seg_d = 7'b0111111;
      else if (lz_blank && idx_d != '0 && !nz_hi)       seg_d = 7'b1111111;
      else                                              seg_d = hex7(nib);
    end

    ready_d = !pend_full_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BLANK;
      idx_q        <= '0;
      disp_val_q   <= '0;
      disp_neg_q   <= 1'b0;
      pend_val_q   <= '0;
      pend_neg_q   <= 1'b0;
      pend_full_q  <= 1'b0;
      ready_q      <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'b1111111;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      disp_val_q   <= disp_val_d;
      disp_neg_q   <= disp_neg_d;
      pend_val_q   <= pend_val_d;
      pend_neg_q   <= pend_neg_d;
      pend_full_q  <= pend_full_d;
      ready_q      <= ready_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign load_ready = ready_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (DIGITS=4); inputs change and outputs are sampled on negedge.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, rotate, load_valid, load_neg, lz_blank;
  logic        load_ready, frame_done;
  logic [15:0] load_data;
  logic [3:0]  an;
  logic [6:0]  seg;

  int n_chk  = 0;
  int n_fail = 0;

  seg_scan_ctrl #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst), .rotate(rotate), .load_valid(load_valid),
    .load_ready(load_ready), .load_data(load_data), .load_neg(load_neg),
    .lz_blank(lz_blank), .an(an), .seg(seg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic rot();
    rotate = 1'b1;
    @(negedge clk);
    rotate = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (an !== 4'b1111) begin n_fail++; $display("FAIL rst_an got %b exp 1111", an); end
    n_chk++; if (seg !== 7'b1111111) begin n_fail++; $display("FAIL rst_seg got %b exp 1111111", seg); end
    n_chk++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_fd got %b exp 0", frame_done); end
    n_chk++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b exp 0", load_ready); end
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      n_chk++;
      if (an !== 4'b1111 || seg !== 7'b1111111 || load_ready !== 1'b1 || frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_c%0d got an=%b seg=%b rdy=%b fd=%b exp an=1111 seg=1111111 rdy=1 fd=0",
                 c, an, seg, load_ready, frame_done);
      end
    end
  endtask

  task automatic test_basic();
    logic [6:0] es[4];
    logic [3:0] ea;
    es[0] = 7'b1000000; es[1] = 7'b1111000; es[2] = 7'b0001000; es[3] = 7'b1111001;
    lz_blank = 1'b0;
    load_valid = 1'b1; load_data = 16'h1A70; load_neg = 1'b0;
    @(negedge clk);
    load_valid = 1'b0;
    n_chk++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_fall got %b exp 0", load_ready); end
    repeat (3) @(negedge clk);
    n_chk++; if (an !== 4'b1111) begin n_fail++; $display("FAIL basic_pre_an got %b exp 1111", an); end
    for (int r = 0; r < 8; r++) begin
      rot();
      ea = ~(4'b0001 << (r % 4));
      n_chk++; if (an !== ea) begin n_fail++; $display("FAIL basic_an_r%0d got %b exp %b", r+1, an, ea); end
      n_chk++; if (seg !== es[r%4]) begin n_fail++; $display("FAIL basic_seg_r%0d got %b exp %b", r+1, seg, es[r%4]); end
      n_chk++; if (frame_done !== (r % 4 == 0)) begin n_fail++; $display("FAIL basic_fd_r%0d got %b exp %b", r+1, frame_done, (r % 4 == 0)); end
      n_chk++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_r%0d got %b exp 1", r+1, load_ready); end
      @(negedge clk);
      n_chk++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL basic_fd_hold_r%0d got %b exp 0", r+1, frame_done); end
      n_chk++; if (seg !== es[r%4]) begin n_fail++; $display("FAIL basic_hold_r%0d got %b exp %b", r+1, seg, es[r%4]); end
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_lz();
    logic [6:0] es[4];
    lz_blank = 1'b1;
    load_valid = 1'b1; load_data = 16'h0007; load_neg = 1'b0;
    @(negedge clk);
    load_valid = 1'b0;
    es[0] = 7'b1111000; es[1] = 7'b1111111; es[2] = 7'b1111111; es[3] = 7'b1111111;
    for (int d = 0; d < 4; d++) begin
      rot();
      n_chk++; if (an !== ~(4'b0001 << d)) begin n_fail++; $display("FAIL lz1_an_d%0d got %b", d, an); end
      n_chk++; if (seg !== es[d]) begin n_fail++; $display("FAIL lz1_seg_d%0d got %b exp %b", d, seg, es[d]); end
    end
    lz_blank = 1'b0;
    es[1] = 7'b1000000; es[2] = 7'b1000000; es[3] = 7'b1000000;
    for (int d = 0; d < 4; d++) begin
      rot();
      n_chk++; if (seg !== es[d]) begin n_fail++; $display("FAIL lz0_seg_d%0d got %b exp %b", d, seg, es[d]); end
    end
  endtask

  task automatic test_neg();
    logic [6:0] es[4];
    lz_blank = 1'b1;
    load_valid = 1'b1; load_data = 16'h0012; load_neg = 1'b1;
    @(negedge clk);
    load_valid = 1'b0; load_neg = 1'b0;
    es[0] = 7'b0100100; es[1] = 7'b1111001; es[2] = 7'b1111111; es[3] = 7'b0111111;
    for (int d = 0; d < 4; d++) begin
      rot();
      n_chk++; if (seg !== es[d]) begin n_fail++; $display("FAIL neg_seg_d%0d got %b exp %b", d, seg, es[d]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ea_seg[4];
    logic [6:0] eb_seg[4];
    ea_seg[0] = 7'b0000010; ea_seg[1] = 7'b0010010; ea_seg[2] = 7'b0011001; ea_seg[3] = 7'b0110000;
    eb_seg[0] = 7'b0000011; eb_seg[1] = 7'b0001000; eb_seg[2] = 7'b0010000; eb_seg[3] = 7'b0000000;
    rot(); rot();
    load_valid = 1'b1; load_data = 16'h3456; load_neg = 1'b0;
    @(negedge clk);
    load_data = 16'h89AB;
    n_chk++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_a_accept got %b exp 0", load_ready); end
    @(negedge clk);
    n_chk++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_b_held got %b exp 0", load_ready); end
    rot();
    n_chk++; if (seg !== 7'b1111111) begin n_fail++; $display("FAIL b2b_old_d2 got %b exp 1111111", seg); end
    rot();
    n_chk++; if (seg !== 7'b0111111) begin n_fail++; $display("FAIL b2b_old_d3 got %b exp 0111111", seg); end
    n_chk++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_held_d3 got %b exp 0", load_ready); end
    rot();
    n_chk++; if (seg !== ea_seg[0]) begin n_fail++; $display("FAIL b2b_a_d0 got %b exp %b", seg, ea_seg[0]); end
    n_chk++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL b2b_a_fd got %b exp 1", frame_done); end
    n_chk++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_rise got %b exp 1", load_ready); end
    @(negedge clk);
    load_valid = 1'b0;
    n_chk++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_b_accept got %b exp 0", load_ready); end
    for (int d = 1; d < 4; d++) begin
      rot();
      n_chk++; if (seg !== ea_seg[d]) begin n_fail++; $display("FAIL b2b_a_d%0d got %b exp %b", d, seg, ea_seg[d]); end
    end
    for (int d = 0; d < 4; d++) begin
      rot();
      n_chk++; if (seg !== eb_seg[d]) begin n_fail++; $display("FAIL b2b_b_d%0d got %b exp %b", d, seg, eb_seg[d]); end
    end
    // Load posted on the wrap strobe edge itself: must wait a whole frame.
    rotate = 1'b1; load_valid = 1'b1; load_data = 16'h0C0D;
    @(negedge clk);
    rotate = 1'b0; load_valid = 1'b0;
    n_chk++; if (seg !== eb_seg[0]) begin n_fail++; $display("FAIL wrapload_d0 got %b exp %b", seg, eb_seg[0]); end
    n_chk++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL wrapload_fd got %b exp 1", frame_done); end
    n_chk++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL wrapload_ready got %b exp 0", load_ready); end
    for (int d = 1; d < 4; d++) begin
      rot();
      n_chk++; if (seg !== eb_seg[d]) begin n_fail++; $display("FAIL wrapload_b_d%0d got %b exp %b", d, seg, eb_seg[d]); end
    end
    rot();
    n_chk++; if (seg !== 7'b0100001) begin n_fail++; $display("FAIL wrapload_c_d0 got %b exp 0100001", seg); end
    n_chk++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL wrapload_c_ready got %b exp 1", load_ready); end
  endtask

  task automatic test_rst_mid();
    rot();
    n_chk++; if (seg !== 7'b1000000) begin n_fail++; $display("FAIL rstmid_c_d1 got %b exp 1000000", seg); end
    load_valid = 1'b1; load_data = 16'h5555;
    @(negedge clk);
    load_valid = 1'b0;
    n_chk++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_full got %b exp 0", load_ready); end
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if (an !== 4'b1111) begin n_fail++; $display("FAIL rstmid_an got %b exp 1111", an); end
    n_chk++; if (seg !== 7'b1111111) begin n_fail++; $display("FAIL rstmid_seg got %b exp 1111111", seg); end
    n_chk++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready got %b exp 0", load_ready); end
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready_rel got %b exp 1", load_ready); end
    rot();
    n_chk++; if (an !== 4'b1110) begin n_fail++; $display("FAIL rstmid_an0 got %b exp 1110", an); end
    n_chk++; if (seg !== 7'b1000000) begin n_fail++; $display("FAIL rstmid_seg0 got %b exp 1000000", seg); end
    n_chk++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL rstmid_fd got %b exp 1", frame_done); end
    rot();
    n_chk++; if (seg !== 7'b1111111) begin n_fail++; $display("FAIL rstmid_lost_d1 got %b exp 1111111", seg); end
  endtask

  initial begin
    rst = 1'b1; rotate = 1'b0; load_valid = 1'b0; load_data = '0; load_neg = 1'b0; lz_blank = 1'b0;
    test_reset();
    test_basic();
    test_lz();
    test_neg();
    test_back_to_back();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
